cim_array_ctrl: RTL and testbench

- Registered command decoder for the compute-in-memory array; replaces and keeps the port list of array_ctrl.
- Turns a 2-bit op_code plus bank/column address and two 16-bit data words into array control signals.
- Control signals: one-hot bank select, one-hot column select, write enable, MAC enable, write/search data, MAC activation vector.
- Sits between the top-level command interface and the SRAM bank array / MAC datapath.

---
 rtl/array_ctrl_pkg.sv | 17 +
 rtl/array_ctrl_onehot_dec.sv | 17 +
 rtl/cim_array_ctrl.sv | 109 ++++++++++
 tb/tb_cim_array_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/array_ctrl_pkg.sv
// Shared op-codes and default geometry for the CIM array controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package array_ctrl_pkg;

    // Command encoding on op_code
    localparam logic [1:0] OP_MAC   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CAM   = 2'b10;
    localparam logic [1:0] OP_IDLE  = 2'b11;

    // Default array geometry
    localparam int DEFAULT_NUM_BANKS = 16;
    localparam int DEFAULT_NUM_COLS  = 8;
    localparam int DEFAULT_DATA_W    = 16;

endpackage

// File: rtl/array_ctrl_onehot_dec.sv
// Purely combinational N-to-2^N one-hot decoder.
// Latency: 0 cycles.
// Backpressure: none (combinational).
module array_ctrl_onehot_dec #(
    parameter int N = 4
) (
    input  logic [N-1:0]      idx,
    output logic [(1<<N)-1:0] onehot
);

    // Exactly one output bit set, selected by idx
    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/cim_array_ctrl.sv
// Registered command decoder: op_code/address/data -> CIM array control signals.
// Latency: 1 cycle, one command accepted every cycle.
// Backpressure: none; optional macro ARRAY_CTRL_MAC_MASK_EN enables multi-bank MAC broadcast.
module cim_array_ctrl
    import array_ctrl_pkg::*;
#(
    parameter int NUM_BANKS = DEFAULT_NUM_BANKS,
    parameter int NUM_COLS  = DEFAULT_NUM_COLS,
    parameter int DATA_W    = DEFAULT_DATA_W,
    localparam int BANK_AW  = $clog2(NUM_BANKS),
    localparam int COL_AW   = $clog2(NUM_COLS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           op_code,
    input  logic [BANK_AW-1:0]   addr_bank,
    input  logic [COL_AW-1:0]    addr_col,
    input  logic [DATA_W-1:0]    data_bank,
    input  logic [DATA_W-1:0]    data_in,
    output logic                 mac_en,
    output logic [DATA_W-1:0]    data_op,
    output logic [NUM_BANKS-1:0] bank_mux,
    output logic                 w_en,
    output logic [DATA_W-1:0]    data_and,
    output logic [NUM_COLS-1:0]  col_mux
);

    logic [NUM_BANKS-1:0] bank_onehot;
    logic [NUM_COLS-1:0]  col_onehot;

    logic                 mac_en_nxt;
    logic                 w_en_nxt;
    logic [NUM_BANKS-1:0] bank_mux_nxt;
    logic [NUM_COLS-1:0]  col_mux_nxt;
    logic [DATA_W-1:0]    data_op_nxt;
    logic [DATA_W-1:0]    data_and_nxt;

    array_ctrl_onehot_dec #(.N(BANK_AW)) u_bank_dec (
        .idx    (addr_bank),
        .onehot (bank_onehot)
    );

    array_ctrl_onehot_dec #(.N(COL_AW)) u_col_dec (
        .idx    (addr_col),
        .onehot (col_onehot)
    );

    // Decode the current command; every field not used by the op is forced to 0
    always_comb begin
        mac_en_nxt   = 1'b0;
        w_en_nxt     = 1'b0;
        bank_mux_nxt = '0;
        col_mux_nxt  = '0;
        data_op_nxt  = '0;
        data_and_nxt = '0;
        case (op_code)
            OP_WRITE: begin
                w_en_nxt     = 1'b1;
                bank_mux_nxt = bank_onehot;
                col_mux_nxt  = col_onehot;
                data_op_nxt  = data_bank;
            end
            OP_MAC: begin
                mac_en_nxt   = 1'b1;
                col_mux_nxt  = col_onehot;
                data_and_nxt = data_in;
`ifdef ARRAY_CTRL_MAC_MASK_EN
                // A non-zero bank mask broadcasts the MAC to several banks
                if (data_bank != '0) begin
                    bank_mux_nxt = data_bank[NUM_BANKS-1:0];
                end else begin
                    bank_mux_nxt = bank_onehot;
                end
`else
                bank_mux_nxt = bank_onehot;
`endif
            end
            OP_CAM: begin
                // Masked banks search in parallel; a zero mask selects nothing
                bank_mux_nxt = data_bank[NUM_BANKS-1:0];
                col_mux_nxt  = col_onehot;
                data_op_nxt  = data_in;
            end
            default: begin
                // IDLE: everything stays at 0
            end
        endcase
    end

    // Output registers; reset (rst_n high despite its name) clears everything
    always_ff @(posedge clk) begin
        if (rst_n) begin
            mac_en   <= 1'b0;
            w_en     <= 1'b0;
            bank_mux <= '0;
            col_mux  <= '0;
            data_op  <= '0;
            data_and <= '0;
        end else begin
            mac_en   <= mac_en_nxt;
            w_en     <= w_en_nxt;
            bank_mux <= bank_mux_nxt;
            col_mux  <= col_mux_nxt;
            data_op  <= data_op_nxt;
            data_and <= data_and_nxt;
        end
    end

endmodule

// File: tb/tb_cim_array_ctrl.sv
// Scoreboard bench for cim_array_ctrl: expected outputs queued per command.
// Latency: results compared one cycle after each command is driven.
// Backpressure: none; one command per cycle.
module tb_cim_array_ctrl;
    import array_ctrl_pkg::*;

    typedef struct packed {
        logic        mac_en;
        logic        w_en;
        logic [15:0] bank_mux;
        logic [7:0]  col_mux;
        logic [15:0] data_op;
        logic [15:0] data_and;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  op_code = OP_IDLE;
    logic [3:0]  addr_bank = '0;
    logic [2:0]  addr_col = '0;
    logic [15:0] data_bank = '0;
    logic [15:0] data_in = '0;
    logic        mac_en;
    logic [15:0] data_op;
    logic [15:0] bank_mux;
    logic        w_en;
    logic [15:0] data_and;
    logic [7:0]  col_mux;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cim_array_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_code   (op_code),
        .addr_bank (addr_bank),
        .addr_col  (addr_col),
        .data_bank (data_bank),
        .data_in   (data_in),
        .mac_en    (mac_en),
        .data_op   (data_op),
        .bank_mux  (bank_mux),
        .w_en      (w_en),
        .data_and  (data_and),
        .col_mux   (col_mux)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Behavioural reference for one command
    function automatic exp_t model(input logic rst, input logic [1:0] op, input logic [3:0] b,
                                   input logic [2:0] c, input logic [15:0] db, input logic [15:0] di);
        exp_t e;
        e = '0;
        if (!rst) begin
            case (op)
                OP_WRITE: begin
                    e.w_en     = 1'b1;
                    e.bank_mux = 16'h0001 << b;
                    e.col_mux  = 8'h01 << c;
                    e.data_op  = db;
                end
                OP_MAC: begin
                    e.mac_en   = 1'b1;
                    e.bank_mux = 16'h0001 << b;
`ifdef ARRAY_CTRL_MAC_MASK_EN
                    if (db != 16'h0000) e.bank_mux = db;
`endif
                    e.col_mux  = 8'h01 << c;
                    e.data_and = di;
                end
                OP_CAM: begin
                    e.bank_mux = db;
                    e.col_mux  = 8'h01 << c;
                    e.data_op  = di;
                end
                default: e = '0;
            endcase
        end
        return e;
    endfunction

    // Pop the oldest expectation and compare against the registered outputs
    task automatic compare_head();
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("mac_en",   {31'b0, mac_en}, {31'b0, e.mac_en});
            chk("w_en",     {31'b0, w_en},   {31'b0, e.w_en});
            chk("excl",     {31'b0, mac_en & w_en}, 32'd0);
            chk("bank_mux", {16'b0, bank_mux}, {16'b0, e.bank_mux});
            chk("col_mux",  {24'b0, col_mux},  {24'b0, e.col_mux});
            chk("data_op",  {16'b0, data_op},  {16'b0, e.data_op});
            chk("data_and", {16'b0, data_and}, {16'b0, e.data_and});
        end
    endtask

    // Check the previous command's result, then drive and queue the next one
    task automatic apply(input logic rst, input logic [1:0] op, input logic [3:0] b,
                         input logic [2:0] c, input logic [15:0] db, input logic [15:0] di);
        @(negedge clk);
        compare_head();
        rst_n     = rst;
        op_code   = op;
        addr_bank = b;
        addr_col  = c;
        data_bank = db;
        data_in   = di;
        exp_q.push_back(model(rst, op, b, c, db, di));
    endtask

    initial begin
        // Reset held for two edges with a non-idle op, then IDLE after release
        apply(1'b1, OP_WRITE, 4'd5, 3'd2, 16'hAAAA, 16'h5555);
        apply(1'b1, OP_IDLE,  4'd0, 3'd0, 16'h0000, 16'h0000);
        apply(1'b0, OP_IDLE,  4'd0, 3'd0, 16'h0000, 16'h0000);
        apply(1'b0, OP_IDLE,  4'd0, 3'd0, 16'h0000, 16'h0000);

        // Single WRITE
        apply(1'b0, OP_WRITE, 4'd3, 3'd0, 16'h0006, 16'h1234);

        // WRITE sweep over every bank, column and data varying
        for (int i = 0; i < 16; i++) begin
            apply(1'b0, OP_WRITE, 4'(i), 3'(i % 8), 16'(i + 16'h0100 * (i % 8)), 16'hDEAD);
        end

        // MAC basic, then MAC with a non-zero bank mask
        apply(1'b0, OP_MAC, 4'd0, 3'd0, 16'h0000, 16'hF0FF);
        apply(1'b0, OP_MAC, 4'd0, 3'd0, 16'h0010, 16'h00FF);
        apply(1'b0, OP_MAC, 4'd15, 3'd7, 16'h0000, 16'h8001);

        // CAM, CAM with empty mask, then IDLE
        apply(1'b0, OP_CAM, 4'd9, 3'd0, 16'h000F, 16'hFFFF);
        apply(1'b0, OP_CAM, 4'd2, 3'd7, 16'h0000, 16'hA5A5);
        apply(1'b0, OP_IDLE, 4'd7, 3'd3, 16'hFFFF, 16'hFFFF);

        // Back-to-back op switching
        apply(1'b0, OP_WRITE, 4'd15, 3'd7, 16'hFFFF, 16'hFFFF);
        apply(1'b0, OP_MAC,   4'd1,  3'd1, 16'hFFFF, 16'h1111);
        apply(1'b0, OP_CAM,   4'd2,  3'd2, 16'h8421, 16'h2222);
        apply(1'b0, OP_WRITE, 4'd4,  3'd4, 16'h3333, 16'h4444);

        // Reset mid-stream, then resume
        apply(1'b1, OP_MAC,   4'd6,  3'd5, 16'h0000, 16'h7777);
        apply(1'b0, OP_MAC,   4'd6,  3'd5, 16'h0000, 16'h7777);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            apply(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
        end

        // Drain the last expectation
        apply(1'b0, OP_IDLE, 4'd0, 3'd0, 16'h0000, 16'h0000);
        @(negedge clk);
        compare_head();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
